// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status constants, parser state enum and data-length helper
package midi_pkg;
  localparam logic [7:0] ST_NOTE_OFF = 8'h80;
  localparam logic [7:0] ST_NOTE_ON  = 8'h90;
  localparam logic [7:0] ST_SYSEX    = 8'hF0;
  localparam logic [7:0] ST_EOX      = 8'hF7;
  localparam logic [7:0] ST_TUNE     = 8'hF6;
  localparam logic [7:0] RT_BASE     = 8'hF8;
  typedef enum logic [1:0] {IDLE, CHAN, SYSX, SCOM} parse_state_e;
  function automatic logic [7:0] midi_data_len(input logic [7:0] status);
    return (status == ST_SYSEX) ? 8'hFF :
           (status[7:4] == 4'hF && status != 8'hF1 && status != 8'hF2 && status != 8'hF3) ? 8'd0 :
           (status[7:5] == 3'b110 || status == 8'hF1 || status == 8'hF3) ? 8'd1 : 8'd2;
  endfunction
endpackage

// File: rtl/midi_rx_fifo.sv
// midi_rx_fifo: single-clock show-ahead byte FIFO between the UART receiver and the parser
module midi_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign empty   = cnt_q == '0;
  assign full    = cnt_q[AW];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/midi_stream_parser.sv
// midi_stream_parser: buffers raw MIDI bytes and emits parsed bytes with running status,
// byte numbering, sysex framing and real-time interleaving resolved
module midi_stream_parser
  import midi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       ovf_clr,
  output logic       byteready_u,
  output logic [7:0] cur_status_u,
  output logic [7:0] midibyte_nr_u,
  output logic [7:0] midi_in_data_u,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       overflow,
  output logic [7:0] orphan_cnt
);
  logic [7:0]   b;
  logic         empty, full, pop;
  parse_state_e state_q, state_d;
  logic [7:0]   cur_q, cur_d, nr_q, nr_d, need_q, need_d, nr_inc, em_status, em_nr;
  logic         emit, rt, orphan;
  logic         byteready_q, rt_valid_q, ovf_q;
  logic [7:0]   st_o_q, nr_o_q, data_o_q, rt_byte_q, orphan_q;
  assign pop            = !empty;
  assign rx_ready       = !full;
  assign byteready_u    = byteready_q;
  assign cur_status_u   = st_o_q;
  assign midibyte_nr_u  = nr_o_q;
  assign midi_in_data_u = data_o_q;
  assign rt_valid       = rt_valid_q;
  assign rt_byte        = rt_byte_q;
  assign overflow       = ovf_q;
  assign orphan_cnt     = orphan_q;
  assign nr_inc         = (nr_q == 8'hFF) ? 8'hFF : nr_q + 8'd1;
  midi_rx_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk   (reg_clk),
    .rst_n (reset_reg_N),
    .push  (rx_valid),
    .pop   (pop),
    .din   (rx_byte),
    .dout  (b),
    .empty (empty),
    .full  (full)
  );
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    nr_d      = nr_q;
    need_d    = need_q;
    emit      = 1'b0;
    rt        = 1'b0;
    orphan    = 1'b0;
    em_status = cur_q;
    em_nr     = nr_q;
    if (pop) begin
      if (b >= RT_BASE) begin
        rt = 1'b1;
      end else if (b == ST_EOX) begin
        emit    = state_q == SYSX;
        em_nr   = nr_inc;
        state_d = IDLE;
        cur_d   = 8'h00;
      end else if (b == 8'hF4 || b == 8'hF5) begin
        state_d = IDLE;
        cur_d   = 8'h00;
      end else if (b >= ST_NOTE_OFF) begin
        emit      = 1'b1;
        em_status = b;
        em_nr     = 8'd0;
        nr_d      = 8'd0;
        need_d    = midi_data_len(b);
        cur_d     = (b == ST_TUNE) ? 8'h00 : b;
        state_d   = (b == ST_SYSEX) ? SYSX : (b == ST_TUNE) ? IDLE : (b[7:4] == 4'hF) ? SCOM : CHAN;
      end else if (state_q == IDLE) begin
        orphan = 1'b1;
      end else if (state_q == SYSX) begin
        emit  = 1'b1;
        nr_d  = nr_inc;
        em_nr = nr_inc;
      end else begin
        // running status: a full message wraps numbering back to the first data byte
        emit  = 1'b1;
        nr_d  = (nr_q == need_q) ? 8'd1 : nr_inc;
        em_nr = nr_d;
        if (state_q == SCOM && nr_d == need_q) begin
          state_d = IDLE;
          cur_d   = 8'h00;
        end
      end
    end
  end
  always_ff @(posedge reg_clk or negedge reset_reg_N)
    if (!reset_reg_N) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      nr_q        <= '0;
      need_q      <= '0;
      byteready_q <= 1'b0;
      rt_valid_q  <= 1'b0;
      ovf_q       <= 1'b0;
      st_o_q      <= '0;
      nr_o_q      <= '0;
      data_o_q    <= '0;
      rt_byte_q   <= '0;
      orphan_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      nr_q        <= nr_d;
      need_q      <= need_d;
      byteready_q <= emit;
      rt_valid_q  <= rt;
      if (emit) begin
        st_o_q   <= em_status;
        nr_o_q   <= em_nr;
        data_o_q <= b;
      end
      if (rt) rt_byte_q <= b;
      if (orphan && orphan_q != 8'hFF) orphan_q <= orphan_q + 8'd1;
      if (rx_valid && full) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
endmodule

// File: tb/tb_midi_stream_parser.sv
// tb_midi_stream_parser: directed self-checking bench for midi_stream_parser
module tb_midi_stream_parser;
  logic       reg_clk = 1'b0;
  logic       reset_reg_N = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       ovf_clr = 1'b0;
  logic       byteready_u, rt_valid, overflow;
  logic [7:0] cur_status_u, midibyte_nr_u, midi_in_data_u, rt_byte, orphan_cnt;
  typedef struct {int cyc; logic [7:0] st; logic [7:0] nr; logic [7:0] d;} ev_t;
  ev_t        evq[$];
  logic [7:0] rtq[$];
  int         dq[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  midi_stream_parser #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .reg_clk        (reg_clk),
    .reset_reg_N    (reset_reg_N),
    .rx_byte        (rx_byte),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .ovf_clr        (ovf_clr),
    .byteready_u    (byteready_u),
    .cur_status_u   (cur_status_u),
    .midibyte_nr_u  (midibyte_nr_u),
    .midi_in_data_u (midi_in_data_u),
    .rt_valid       (rt_valid),
    .rt_byte        (rt_byte),
    .overflow       (overflow),
    .orphan_cnt     (orphan_cnt)
  );
  always #5 reg_clk = ~reg_clk;
  always @(posedge reg_clk) cyc <= cyc + 1;
  always @(negedge reg_clk) begin
    if (byteready_u) evq.push_back('{cyc, cur_status_u, midibyte_nr_u, midi_in_data_u});
    if (rt_valid) rtq.push_back(rt_byte);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    dq.push_back(cyc);
    @(negedge reg_clk);
    rx_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge reg_clk);
  endtask
  task automatic clr();
    evq.delete();
    rtq.delete();
    dq.delete();
  endtask
  task automatic chk_ev(input string tag, input int i, input logic [7:0] st, input logic [7:0] nr, input logic [7:0] d);
    if (i < evq.size()) begin
      chk({tag, " status"}, evq[i].st, st);
      chk({tag, " nr"}, evq[i].nr, nr);
      chk({tag, " data"}, evq[i].d, d);
    end else chk({tag, " present"}, 0, 1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " byteready"}, byteready_u, 0);
    chk({tag, " rt_valid"}, rt_valid, 0);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " cur_status"}, cur_status_u, 0);
    chk({tag, " nr"}, midibyte_nr_u, 0);
    chk({tag, " data"}, midi_in_data_u, 0);
    chk({tag, " rt_byte"}, rt_byte, 0);
    chk({tag, " orphan"}, orphan_cnt, 0);
    chk({tag, " rx_ready"}, rx_ready, 1);
  endtask
  initial begin
    logic [7:0] note_d [5] = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00};
    logic [7:0] note_n [5] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2};
    idle(2);
    reset_reg_N = 1'b1;
    idle(1);
    chk_zero("reset");
    clr();
    for (int i = 0; i < 5; i++) send(note_d[i]);
    idle(4);
    chk("note count", evq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk_ev($sformatf("note%0d", i), i, 8'h90, note_n[i], note_d[i]);
      if (i < evq.size()) chk($sformatf("note%0d latency", i), evq[i].cyc - dq[i], 2);
    end
    clr();
    send(8'hC3); send(8'h05); send(8'h07);
    idle(4);
    chk("pc count", evq.size(), 3);
    chk_ev("pc0", 0, 8'hC3, 0, 8'hC3);
    chk_ev("pc1", 1, 8'hC3, 1, 8'h05);
    chk_ev("pc2", 2, 8'hC3, 1, 8'h07);
    clr();
    send(8'hF0); send(8'h7D); send(8'hF8); send(8'h01); send(8'hF7);
    idle(4);
    chk("sysex count", evq.size(), 4);
    chk_ev("sx0", 0, 8'hF0, 0, 8'hF0);
    chk_ev("sx1", 1, 8'hF0, 1, 8'h7D);
    chk_ev("sx2", 2, 8'hF0, 2, 8'h01);
    chk_ev("sx3", 3, 8'hF0, 3, 8'hF7);
    chk("sysex rt count", rtq.size(), 1);
    if (rtq.size() > 0) chk("sysex rt byte", rtq[0], 8'hF8);
    send(8'h10);
    idle(4);
    chk("post-eox no emit", evq.size(), 4);
    chk("post-eox orphan", orphan_cnt, 1);
    clr();
    send(8'hF6); send(8'h11);
    idle(4);
    chk("tune count", evq.size(), 1);
    chk_ev("tune", 0, 8'hF6, 0, 8'hF6);
    chk("tune orphan", orphan_cnt, 2);
    clr();
    send(8'hF2); send(8'h01); send(8'h02); send(8'h03);
    idle(4);
    chk("spp count", evq.size(), 3);
    chk_ev("spp0", 0, 8'hF2, 0, 8'hF2);
    chk_ev("spp2", 2, 8'hF2, 2, 8'h02);
    chk("spp orphan", orphan_cnt, 3);
    clr();
    send(8'h3C); send(8'h40);
    idle(4);
    chk("orphan no emit", evq.size(), 0);
    chk("orphan cnt", orphan_cnt, 5);
    clr();
    force dut.pop = 1'b0;
    for (int i = 0; i < 16; i++) send(8'hF8);
    chk("full rx_ready", rx_ready, 0);
    chk("full no ovf", overflow, 0);
    send(8'hF9);
    chk("ovf set", overflow, 1);
    release dut.pop;
    chk("full pop rx_ready", rx_ready, 0);
    idle(1);
    chk("after pop rx_ready", rx_ready, 1);
    idle(20);
    chk("drain rt count", rtq.size(), 16);
    if (rtq.size() > 15) chk("drain last rt", rtq[15], 8'hF8);
    chk("ovf sticky", overflow, 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("ovf cleared", overflow, 0);
    send(8'h90); send(8'h3C);
    reset_reg_N = 1'b0;
    idle(1);
    reset_reg_N = 1'b1;
    chk_zero("midreset");
    clr();
    send(8'h40);
    idle(4);
    chk("midreset orphan", orphan_cnt, 1);
    chk("midreset no emit", evq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
